// File: rtl/acc_dispatch_if.sv
//------------------------------------------------------------------------------
// acc_dispatch_if : requester and accelerator bus bundle for acc_dispatch
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface acc_dispatch_if #(
    parameter int DataWidth = 32,
    parameter int IdWidth   = 5,
    parameter int NumAcc    = 4,
    parameter int AddrWidth = 4
) ();
    logic [AddrWidth-1:0]                q_addr;
    logic [31:0]                         q_data_op;
    logic [DataWidth-1:0]                q_data_arga;
    logic [DataWidth-1:0]                q_data_argb;
    logic [DataWidth-1:0]                q_data_argc;
    logic [IdWidth-1:0]                  q_id;
    logic                                q_writeback;
    logic                                q_valid;
    logic                                q_ready;

    logic [DataWidth-1:0]                p_data0;
    logic [DataWidth-1:0]                p_data1;
    logic                                p_dual_writeback;
    logic [IdWidth-1:0]                  p_id;
    logic                                p_error;
    logic                                p_valid;
    logic                                p_ready;

    logic [31:0]                         acc_q_op;
    logic [DataWidth-1:0]                acc_q_arga;
    logic [DataWidth-1:0]                acc_q_argb;
    logic [DataWidth-1:0]                acc_q_argc;
    logic [IdWidth-1:0]                  acc_q_id;
    logic [NumAcc-1:0]                   acc_q_valid;
    logic [NumAcc-1:0]                   acc_q_ready;

    logic [NumAcc-1:0][DataWidth-1:0]    acc_p_data0;
    logic [NumAcc-1:0][DataWidth-1:0]    acc_p_data1;
    logic [NumAcc-1:0]                   acc_p_dual_writeback;
    logic [NumAcc-1:0]                   acc_p_error;
    logic [NumAcc-1:0][IdWidth-1:0]      acc_p_id;
    logic [NumAcc-1:0]                   acc_p_valid;
    logic [NumAcc-1:0]                   acc_p_ready;

    // Dispatcher view
    modport slave (
        input  q_addr, q_data_op, q_data_arga, q_data_argb, q_data_argc,
               q_id, q_writeback, q_valid,
        output q_ready,
        output p_data0, p_data1, p_dual_writeback, p_id, p_error, p_valid,
        input  p_ready,
        output acc_q_op, acc_q_arga, acc_q_argb, acc_q_argc, acc_q_id, acc_q_valid,
        input  acc_q_ready,
        input  acc_p_data0, acc_p_data1, acc_p_dual_writeback, acc_p_error,
               acc_p_id, acc_p_valid,
        output acc_p_ready
    );

    // Requester plus accelerator-array view
    modport master (
        output q_addr, q_data_op, q_data_arga, q_data_argb, q_data_argc,
               q_id, q_writeback, q_valid,
        input  q_ready,
        input  p_data0, p_data1, p_dual_writeback, p_id, p_error, p_valid,
        output p_ready,
        input  acc_q_op, acc_q_arga, acc_q_argb, acc_q_argc, acc_q_id, acc_q_valid,
        output acc_q_ready,
        output acc_p_data0, acc_p_data1, acc_p_dual_writeback, acc_p_error,
               acc_p_id, acc_p_valid,
        input  acc_p_ready
    );
endinterface

`default_nettype wire

// File: rtl/acc_dispatch.sv
//------------------------------------------------------------------------------
// acc_dispatch : address-decoded request fan-out with credit limits and a
//                registered round-robin response merger.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module acc_dispatch #(
    parameter int DataWidth      = 32,
    parameter int IdWidth        = 5,
    parameter int NumAcc         = 4,
    parameter int AddrWidth      = 4,
    parameter int MaxOutstanding = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    acc_dispatch_if.slave bus,
    output logic          busy_o
);
    localparam int NUM_REQ = NumAcc + 1;
    localparam int PTR_W   = $clog2(NUM_REQ);
    localparam int CNT_W   = $clog2(MaxOutstanding + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MaxOutstanding);
    localparam logic [PTR_W-1:0] ERR_IDX = PTR_W'(NumAcc);

    logic [NumAcc-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0]             ptr_q, ptr_d;
    logic                         err_full_q;
    logic [IdWidth-1:0]           err_id_q;
    logic                         p_valid_q;
    logic [DataWidth-1:0]         p_data0_q, p_data1_q;
    logic                         p_dual_q, p_error_q;
    logic [IdWidth-1:0]           p_id_q;

    logic [31:0]          addr_ext;
    logic                 addr_ok;
    logic [NumAcc-1:0]    credit_ok, q_valid_vec, inc, gnt_oh;
    logic                 port_rdy, err_fire, err_gnt, load, fire, gnt_valid, any_cnt;
    logic [NUM_REQ-1:0]   req;
    logic [PTR_W-1:0]     gnt_idx;
    int                   idx;
    logic [DataWidth-1:0] sel_data0, sel_data1;
    logic                 sel_dual, sel_error;
    logic [IdWidth-1:0]   sel_id;

    assign bus.acc_q_op   = bus.q_data_op;
    assign bus.acc_q_arga = bus.q_data_arga;
    assign bus.acc_q_argb = bus.q_data_argb;
    assign bus.acc_q_argc = bus.q_data_argc;
    assign bus.acc_q_id   = bus.q_id;

    // Request path is purely combinational; held off while reset is asserted.
    always_comb begin
        addr_ext    = 32'(bus.q_addr);
        addr_ok     = addr_ext < 32'(NumAcc);
        port_rdy    = 1'b0;
        credit_ok   = '0;
        q_valid_vec = '0;
        inc         = '0;
        for (int i = 0; i < NumAcc; i++) begin
            credit_ok[i] = !bus.q_writeback || (cnt_q[i] < MAX_CNT);
            if (addr_ok && bus.q_addr == AddrWidth'(i)) begin
                q_valid_vec[i] = rst_ni && bus.q_valid && credit_ok[i];
                port_rdy       = bus.acc_q_ready[i] && credit_ok[i];
            end
            inc[i] = q_valid_vec[i] && bus.acc_q_ready[i] && bus.q_writeback;
        end
        bus.q_ready = rst_ni && (addr_ok ? port_rdy : !err_full_q);
        err_fire    = rst_ni && bus.q_valid && !addr_ok && !err_full_q;
    end

    assign bus.acc_q_valid = q_valid_vec;

    always_comb begin
        req       = {err_full_q, bus.acc_p_valid};
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = PTR_W'(idx);
            end
        end
        load    = rst_ni && (!p_valid_q || bus.p_ready);
        fire    = gnt_valid && load;
        err_gnt = fire && (gnt_idx == ERR_IDX);
        if (fire) ptr_d = err_gnt ? '0 : gnt_idx + PTR_W'(1);
        else      ptr_d = ptr_q;
    end

    // Payload of the granted requestor; the error slot contributes only its ID.
    always_comb begin
        gnt_oh    = '0;
        sel_data0 = '0;
        sel_data1 = '0;
        sel_dual  = 1'b0;
        sel_error = 1'b0;
        sel_id    = '0;
        any_cnt   = 1'b0;
        for (int i = 0; i < NumAcc; i++) begin
            gnt_oh[i] = fire && (gnt_idx == PTR_W'(i));
            if (gnt_idx == PTR_W'(i)) begin
                sel_data0 = bus.acc_p_data0[i];
                sel_data1 = bus.acc_p_data1[i];
                sel_dual  = bus.acc_p_dual_writeback[i];
                sel_error = bus.acc_p_error[i];
                sel_id    = bus.acc_p_id[i];
            end
            cnt_d[i] = cnt_q[i];
            if (inc[i] && !gnt_oh[i])
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            else if (!inc[i] && gnt_oh[i] && cnt_q[i] != '0)
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            any_cnt = any_cnt || (cnt_q[i] != '0);
        end
        if (gnt_idx == ERR_IDX) begin
            sel_error = 1'b1;
            sel_id    = err_id_q;
        end
    end

    assign bus.acc_p_ready = gnt_oh;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            ptr_q      <= '0;
            err_full_q <= 1'b0;
            err_id_q   <= '0;
            p_valid_q  <= 1'b0;
            p_data0_q  <= '0;
            p_data1_q  <= '0;
            p_dual_q   <= 1'b0;
            p_error_q  <= 1'b0;
            p_id_q     <= '0;
        end else begin
            cnt_q <= cnt_d;
            ptr_q <= ptr_d;
            if (err_fire) begin
                err_full_q <= 1'b1;
                err_id_q   <= bus.q_id;
            end else if (err_gnt) begin
                err_full_q <= 1'b0;
            end
            if (fire) begin
                p_valid_q <= 1'b1;
                p_data0_q <= sel_data0;
                p_data1_q <= sel_data1;
                p_dual_q  <= sel_dual;
                p_error_q <= sel_error;
                p_id_q    <= sel_id;
            end else if (bus.p_ready) begin
                p_valid_q <= 1'b0;
            end
        end
    end

    assign bus.p_valid          = p_valid_q;
    assign bus.p_data0          = p_data0_q;
    assign bus.p_data1          = p_data1_q;
    assign bus.p_dual_writeback = p_dual_q;
    assign bus.p_error          = p_error_q;
    assign bus.p_id             = p_id_q;
    assign busy_o               = any_cnt || err_full_q || p_valid_q;
endmodule

`default_nettype wire

// File: tb/tb_acc_dispatch.sv
//------------------------------------------------------------------------------
// tb_acc_dispatch : directed self-checking bench for acc_dispatch
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_acc_dispatch;
    localparam int DW = 32;
    localparam int IW = 5;
    localparam int NA = 4;
    localparam int AW = 4;
    localparam int MO = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int   checks = 0;
    int   failures = 0;

    acc_dispatch_if #(.DataWidth(DW), .IdWidth(IW), .NumAcc(NA), .AddrWidth(AW)) bus ();

    acc_dispatch #(
        .DataWidth(DW), .IdWidth(IW), .NumAcc(NA), .AddrWidth(AW), .MaxOutstanding(MO)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.q_addr = '0; bus.q_data_op = 32'h1234_5678; bus.q_data_arga = '0;
        bus.q_data_argb = '0; bus.q_data_argc = '0; bus.q_id = '0;
        bus.q_writeback = 1'b0; bus.q_valid = 1'b0; bus.p_ready = 1'b1;
        bus.acc_q_ready = '0; bus.acc_p_data0 = '0; bus.acc_p_data1 = '0;
        bus.acc_p_dual_writeback = '0; bus.acc_p_error = '0; bus.acc_p_id = '0;
        bus.acc_p_valid = 4'b0001;

        // Reset state, with a pending response that must not be granted
        #7;
        chk("rst_p_valid", bus.p_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_acc_p_ready", bus.acc_p_ready, 0);
        chk("rst_p_id", bus.p_id, 0);
        bus.acc_p_valid = '0;
        rst_n = 1'b1;
        tick();

        // Basic routed write-back request and response
        bus.q_addr = 4'd2; bus.q_id = 5'd7; bus.q_writeback = 1'b1; bus.q_valid = 1'b1;
        bus.acc_q_ready = 4'b0100;
        #1;
        chk("t1_acc_q_valid", bus.acc_q_valid, 4'b0100);
        chk("t1_q_ready", bus.q_ready, 1);
        chk("t1_acc_q_id", bus.acc_q_id, 7);
        chk("t1_acc_q_op", bus.acc_q_op, 32'h1234_5678);
        tick();
        bus.q_valid = 1'b0; bus.acc_q_ready = '0;
        #1;
        chk("t1_busy_cnt", busy, 1);
        chk("t1_p_valid_idle", bus.p_valid, 0);
        bus.acc_p_valid = 4'b0100; bus.acc_p_id[2] = 5'd7; bus.acc_p_data0[2] = 32'hCAFE;
        #1;
        chk("t1_acc_p_ready", bus.acc_p_ready, 4'b0100);
        tick();
        bus.acc_p_valid = '0;
        #1;
        chk("t1_p_valid", bus.p_valid, 1);
        chk("t1_p_id", bus.p_id, 7);
        chk("t1_p_data0", bus.p_data0, 32'hCAFE);
        chk("t1_p_error", bus.p_error, 0);
        tick();
        chk("t1_drained", bus.p_valid, 0);
        chk("t1_busy_idle", busy, 0);

        // Credit limit of two on port 1
        bus.q_addr = 4'd1; bus.q_id = 5'd1; bus.q_writeback = 1'b1; bus.q_valid = 1'b1;
        bus.acc_q_ready = 4'b0010;
        #1;
        chk("t2_req1_ready", bus.q_ready, 1);
        tick();
        chk("t2_req2_ready", bus.q_ready, 1);
        tick();
        chk("t2_req3_acc_q_valid", bus.acc_q_valid, 0);
        chk("t2_req3_stall", bus.q_ready, 0);
        tick();
        chk("t2_req3_stall2", bus.q_ready, 0);
        bus.acc_p_valid = 4'b0010; bus.acc_p_id[1] = 5'd1; bus.acc_p_data0[1] = 32'h11;
        #1;
        chk("t2_grant1", bus.acc_p_ready, 4'b0010);
        chk("t2_stall_on_grant", bus.q_ready, 0);
        tick();
        bus.acc_p_valid = '0;
        #1;
        chk("t2_req3_ready", bus.q_ready, 1);
        chk("t2_req3_acc_q_valid", bus.acc_q_valid, 4'b0010);
        chk("t2_p_data0", bus.p_data0, 32'h11);
        tick();
        bus.q_valid = 1'b0; bus.acc_q_ready = '0;
        bus.acc_p_valid = 4'b0010;
        tick();
        tick();
        bus.acc_p_valid = '0;
        tick();
        chk("t2_busy_idle", busy, 0);

        // Decode error path
        bus.q_addr = 4'd9; bus.q_id = 5'd3; bus.q_writeback = 1'b0; bus.q_valid = 1'b1;
        #1;
        chk("t3_q_ready", bus.q_ready, 1);
        chk("t3_no_acc_q_valid", bus.acc_q_valid, 0);
        tick();
        bus.q_id = 5'd4;
        #1;
        chk("t3_second_stall", bus.q_ready, 0);
        chk("t3_p_valid_n1", bus.p_valid, 0);
        chk("t3_busy_err", busy, 1);
        tick();
        chk("t3_p_valid", bus.p_valid, 1);
        chk("t3_p_error", bus.p_error, 1);
        chk("t3_p_id", bus.p_id, 3);
        chk("t3_p_data0", bus.p_data0, 0);
        chk("t3_second_ready", bus.q_ready, 1);
        tick();
        bus.q_valid = 1'b0;
        #1;
        chk("t3_drained", bus.p_valid, 0);
        tick();
        chk("t3_p_id2", bus.p_id, 4);
        chk("t3_p_error2", bus.p_error, 1);
        tick();

        // Round-robin order 0, 1, 3, error slot
        bus.q_addr = 4'd9; bus.q_id = 5'd9; bus.q_valid = 1'b1;
        tick();
        bus.q_valid = 1'b0;
        bus.acc_p_valid = 4'b1011;
        bus.acc_p_id[0] = 5'd10; bus.acc_p_id[1] = 5'd11; bus.acc_p_id[3] = 5'd13;
        #1;
        chk("t4_gnt0", bus.acc_p_ready, 4'b0001);
        tick();
        bus.acc_p_valid[0] = 1'b0;
        #1;
        chk("t4_p_id0", bus.p_id, 10);
        chk("t4_p_error0", bus.p_error, 0);
        chk("t4_gnt1", bus.acc_p_ready, 4'b0010);
        tick();
        bus.acc_p_valid[1] = 1'b0;
        #1;
        chk("t4_p_id1", bus.p_id, 11);
        chk("t4_gnt3", bus.acc_p_ready, 4'b1000);
        tick();
        bus.acc_p_valid[3] = 1'b0;
        #1;
        chk("t4_p_id3", bus.p_id, 13);
        chk("t4_gnt_err", bus.acc_p_ready, 0);
        tick();
        chk("t4_p_id_err", bus.p_id, 9);
        chk("t4_p_error_err", bus.p_error, 1);
        chk("t4_p_valid_err", bus.p_valid, 1);
        tick();
        chk("t4_drained", bus.p_valid, 0);

        // Back-pressure holds exactly one response
        bus.p_ready = 1'b0;
        bus.acc_p_valid = 4'b0101;
        bus.acc_p_id[0] = 5'd5; bus.acc_p_data0[0] = 32'h55;
        bus.acc_p_id[2] = 5'd6; bus.acc_p_data0[2] = 32'h66;
        #1;
        chk("t5_gnt0", bus.acc_p_ready, 4'b0001);
        tick();
        bus.acc_p_valid = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t5_hold_valid", bus.p_valid, 1);
            chk("t5_hold_id", bus.p_id, 5);
            chk("t5_hold_data0", bus.p_data0, 32'h55);
            chk("t5_hold_no_ready", bus.acc_p_ready, 0);
            tick();
        end
        bus.p_ready = 1'b1;
        #1;
        chk("t5_gnt2", bus.acc_p_ready, 4'b0100);
        chk("t5_p_id_before", bus.p_id, 5);
        tick();
        bus.acc_p_valid = '0;
        #1;
        chk("t5_p_id_next", bus.p_id, 6);
        chk("t5_p_data0_next", bus.p_data0, 32'h66);
        tick();
        chk("t5_drained", bus.p_valid, 0);
        chk("t5_busy_idle", busy, 0);

        // Asynchronous reset mid-transaction
        bus.q_addr = 4'd0; bus.q_id = 5'd2; bus.q_writeback = 1'b1; bus.q_valid = 1'b1;
        bus.acc_q_ready = 4'b0001;
        #1;
        chk("t6_pre_ready", bus.q_ready, 1);
        tick();
        tick();
        bus.q_valid = 1'b0; bus.acc_q_ready = '0;
        bus.p_ready = 1'b0; bus.acc_p_valid = 4'b1000; bus.acc_p_id[3] = 5'd1;
        tick();
        bus.acc_p_valid = '0;
        #1;
        chk("t6_pre_p_valid", bus.p_valid, 1);
        chk("t6_pre_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_p_valid", bus.p_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_p_id", bus.p_id, 0);
        #1;
        rst_n = 1'b1;
        tick();
        bus.q_valid = 1'b1; bus.acc_q_ready = 4'b0001; bus.p_ready = 1'b1;
        #1;
        chk("t6_post_ready1", bus.q_ready, 1);
        tick();
        chk("t6_post_busy", busy, 1);
        chk("t6_post_ready2", bus.q_ready, 1);
        tick();
        chk("t6_post_full", bus.q_ready, 0);
        bus.q_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
